hex_7seg_mux_driver: RTL and testbench
======================================

// Module: hex_7seg_mux_driver
// PURPOSE
//  Time-multiplexed driver for N_DIGITS hex 7-segment digits that share one segment bus.
//  Holds a shadow register and a display register; new values commit only at the frame boundary, so a frame never shows a mix of old and new digits.
//  Scans digits at a programmable rate, blanks all outputs in a guard window at the start of each digit slot to prevent ghosting, and optionally suppresses leading zeros.
//  Sits between the datapath (value producer) and the board display pins.
// PARAMETERS
//  N_DIGITS        4      number of digits, legal range 1..8
//  REFRESH_DIV     50000  clock cycles per digit slot, must be >= 2
//  GUARD_CYCLES    2      blanked cycles at the start of each slot, must be < REFRESH_DIV
//  SEG_ACTIVE_HIGH 0      0 = segments/dp active-low (common anode); 1 = active-high (common cathode)
//  DIG_ACTIVE_HIGH 0      0 = digit enables active-low; 1 = active-high
// PORTS
//  i_clk      in   1           system clock
//  i_rst      in   1           synchronous reset, active-high
//  i_load     in   1           one-cycle strobe; captures i_value and i_dp into the shadow register
//  i_value    in   4*N_DIGITS  nibble k drives digit k; digit 0 = i_value[3:0] = least significant digit
//  i_dp       in   N_DIGITS    decimal point request per digit
//  i_lz_en    in   1           leading-zero suppression enable, sampled live
//  o_seg      out  7           {a,b,c,d,e,f,g}, physical polarity
//  o_dp       out  1           decimal point, physical polarity
//  o_dig      out  N_DIGITS    digit enables, physical polarity
//  o_pending  out  1           high while the shadow register holds a value not yet committed
// BEHAVIOUR
//  - One clock, i_clk. i_rst is synchronous and active-high.
//  - Reset: prescaler=0, index=0, shadow/display value and dp = 0, o_pending=0.
//    Outputs on the cycle after reset: all digits off, o_seg/o_dp inactive. Active-low example: o_dig=all 1s, o_seg=7'h7F, o_dp=1.
//    Reset asserted mid-slot behaves the same. Scanning restarts with digit 0 at prescaler 0.
//  - Prescaler width: clog2(REFRESH_DIV). Index width: max(1, clog2(N_DIGITS)).
//  - Prescaler counts 0..REFRESH_DIV-1 and wraps to 0. At the wrap (terminal count, TC), index increments; it wraps from N_DIGITS-1 to 0.
//    Frame period = N_DIGITS*REFRESH_DIV cycles.
//  - All outputs are registered and reflect the current prescaler and index with 1 cycle of latency.
//  - Guard window: while prescaler < GUARD_CYCLES, every digit is off and seg/dp are inactive.
//    Otherwise only o_dig[index] is on, and seg/dp show display digit [index].
//  - Glyphs (active-high a..g):
//    0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47.
//    Seg/dp are inverted when SEG_ACTIVE_HIGH=0; digit enables are inverted when DIG_ACTIVE_HIGH=0.
//  - Leading zeros (i_lz_en=1): a digit is blanked (seg inactive, digit enable still on) when it and all higher digits are 0.
//    Digit 0 is never blanked. The dp is shown regardless of blanking.
//  - Load/commit handshake:
//    i_load=1 -> shadow<=i_value/i_dp, o_pending=1 on the next cycle.
//    Commit cycle = TC while index==N_DIGITS-1. On it, display<=shadow and o_pending<=0, so digit 0 of the next frame shows the new value.
//  - Repeated i_load while pending: last write wins; earlier values are never displayed.
//  - i_load on the commit cycle: i_value/i_dp commit directly to display and shadow, and o_pending stays 0.
//  - N_DIGITS=1: commit happens on every TC, and o_dig is constant-on outside the guard window.
// TESTING (N_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, active-low polarity)
//  1 Hold i_rst 3 cycles -> o_dig=4'hF, o_seg=7'h7F, o_dp=1, o_pending=0.
//    Release -> first digit 0 enable (o_dig=4'hE) appears 3 cycles later, after the guard.
//  2 Load 16'h1234 mid-frame -> o_pending=1 until the commit cycle.
//    Next frame: digit0 seg=~7'h33=7'h4C for 6 cycles after a 2-cycle blank, then digits 1..3 show 3,2,1. Slot length = 8 cycles.
//  3 i_lz_en=1, value 16'h0050 -> digits 3,2 blank (seg=7'h7F), digit1 '5' (7'h24), digit0 '0' (7'h01).
//    Value 16'h0000 -> only digit 0 lit.
//  4 Loads 16'h1111 then 16'h2222 while pending -> only 2222 ever displayed; o_pending clears exactly at commit.
//  5 i_load with 16'hABCD on the commit cycle -> digit 0 of the next frame shows 'd' and o_pending never rises.
//  6 i_dp=4'b0100 with value 16'h0000, i_lz_en=1 -> digit 2 lit with dp only (o_seg=7'h7F, o_dp=0) during its slot.

Source files
------------

// File: rtl/hex_7seg_mux_driver.sv
// ---------------------------------------------------------------------------
// hex_7seg_mux_driver
//
// Time-multiplexed driver for N_DIGITS hexadecimal 7-segment digits that
// share a single segment bus. A value written by the datapath first lands in
// a shadow register and is copied into the display register only at the end
// of a full scan frame. A frame therefore never shows a mix of old and new
// digits.
//
// Each digit owns a slot of REFRESH_DIV clock cycles. The first GUARD_CYCLES
// cycles of every slot are blanked: all digit enables are off and seg/dp are
// inactive. This gives the previous digit's driver time to turn off before
// the next digit is lit, which prevents ghosting. Leading-zero suppression
// can be enabled at run time.
//
// Parameters
//   N_DIGITS        number of digits (1..8)
//   REFRESH_DIV     clock cycles per digit slot (>= 2)
//   GUARD_CYCLES    blanked cycles at the start of each slot (< REFRESH_DIV)
//   SEG_ACTIVE_HIGH 0 = seg/dp active-low (common anode), 1 = active-high
//   DIG_ACTIVE_HIGH 0 = digit enables active-low, 1 = active-high
//
// Ports
//   i_clk      system clock
//   i_rst      synchronous reset, active-high
//   i_load     one-cycle strobe, captures i_value/i_dp into the shadow register
//   i_value    nibble k drives digit k (digit 0 = i_value[3:0] = LSD)
//   i_dp       decimal point request per digit
//   i_lz_en    leading-zero suppression enable, sampled live
//   o_seg      {a,b,c,d,e,f,g}, physical polarity
//   o_dp       decimal point, physical polarity
//   o_dig      digit enables, physical polarity
//   o_pending  high while the shadow register holds an uncommitted value
// ---------------------------------------------------------------------------
module hex_7seg_mux_driver #(
  parameter int N_DIGITS        = 4,
  parameter int REFRESH_DIV     = 50000,
  parameter int GUARD_CYCLES    = 2,
  parameter bit SEG_ACTIVE_HIGH = 1'b0,
  parameter bit DIG_ACTIVE_HIGH = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_value,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  i_lz_en,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [N_DIGITS-1:0]   o_dig,
  output logic                  o_pending
);

  // -------------------------------------------------------------------------
  // Widths and constants
  // -------------------------------------------------------------------------
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD_CYCLES);

  // Physical "off" levels for each output group.
  localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_HIGH ? 7'h00 : 7'h7F;
  localparam logic                DP_OFF  = SEG_ACTIVE_HIGH ? 1'b0 : 1'b1;
  localparam logic [N_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_HIGH ? '0 : '1;

  // -------------------------------------------------------------------------
  // Glyph table, active-high {a,b,c,d,e,f,g}
  // -------------------------------------------------------------------------
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h7E;
      4'h1:    g = 7'h30;
      4'h2:    g = 7'h6D;
      4'h3:    g = 7'h79;
      4'h4:    g = 7'h33;
      4'h5:    g = 7'h5B;
      4'h6:    g = 7'h5F;
      4'h7:    g = 7'h70;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h7B;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h1F;
      4'hC:    g = 7'h4E;
      4'hD:    g = 7'h3D;
      4'hE:    g = 7'h4F;
      default: g = 7'h47;
    endcase
    return g;
  endfunction

  // -------------------------------------------------------------------------
  // Scan timing: prescaler inside a slot, index selects the slot's digit
  // -------------------------------------------------------------------------
  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_index;
  logic          w_tc;
  logic          w_last_digit;
  logic          w_commit;

  assign w_tc         = (r_presc == PRESC_LAST);
  assign w_last_digit = (r_index == IDX_LAST);
  // The last slot of the frame ends here. The next cycle starts digit 0 of a
  // new frame, so this is the only point where the display may change.
  assign w_commit     = w_tc && w_last_digit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_index <= '0;
    end else if (w_tc) begin
      r_presc <= '0;
      r_index <= w_last_digit ? '0 : (r_index + IW'(1));
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Shadow / display registers and the pending flag
  // -------------------------------------------------------------------------
  logic [4*N_DIGITS-1:0] r_shadow_val;
  logic [N_DIGITS-1:0]   r_shadow_dp;
  logic [4*N_DIGITS-1:0] r_disp_val;
  logic [N_DIGITS-1:0]   r_disp_dp;
  logic                  r_pending;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (i_load) begin
        r_shadow_val <= i_value;
        r_shadow_dp  <= i_dp;
      end
      if (w_commit) begin
        // A load that coincides with the commit bypasses the shadow, so
        // nothing is left waiting and pending stays low.
        r_disp_val <= i_load ? i_value : r_shadow_val;
        r_disp_dp  <= i_load ? i_dp    : r_shadow_dp;
        r_pending  <= 1'b0;
      end else if (i_load) begin
        r_pending  <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-digit decode of the display register
  // -------------------------------------------------------------------------
  logic [3:0]          w_nib [N_DIGITS];
  logic [N_DIGITS-1:0] w_zero_from;  // digit k and every higher digit are 0
  logic [N_DIGITS-1:0] w_blank;      // digit k is a suppressed leading zero

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign w_nib[gi] = r_disp_val[4*gi +: 4];

    if (gi == N_DIGITS - 1) begin : g_top
      assign w_zero_from[gi] = (w_nib[gi] == 4'h0);
    end else begin : g_lower
      assign w_zero_from[gi] = (w_nib[gi] == 4'h0) && w_zero_from[gi+1];
    end

    // The least significant digit always shows, so a value of zero reads "0"
    // rather than an empty display.
    if (gi == 0) begin : g_lsd
      assign w_blank[gi] = 1'b0;
    end else begin : g_upper
      assign w_blank[gi] = i_lz_en && w_zero_from[gi];
    end
  end

  // -------------------------------------------------------------------------
  // Select the digit addressed by the current slot
  // -------------------------------------------------------------------------
  logic [3:0]          w_cur_nib;
  logic                w_cur_dp;
  logic                w_cur_blank;
  logic [N_DIGITS-1:0] w_dig_onehot;

  always_comb begin
    w_cur_nib    = w_nib[0];
    w_cur_dp     = r_disp_dp[0];
    w_cur_blank  = 1'b0;
    w_dig_onehot = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_index == IW'(k)) begin
        w_cur_nib       = w_nib[k];
        w_cur_dp        = r_disp_dp[k];
        w_cur_blank     = w_blank[k];
        w_dig_onehot[k] = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output stage: next-state in logical polarity, then mapped to the pins
  // -------------------------------------------------------------------------
  logic                w_guard;
  logic [6:0]          w_seg_logic;
  logic [6:0]          w_seg_next;
  logic                w_dp_next;
  logic [N_DIGITS-1:0] w_dig_next;

  assign w_guard = (r_presc < GUARD_END);

  always_comb begin
    // A blanked leading zero keeps its digit enable on, so the dp can still
    // show.
    w_seg_logic = w_cur_blank ? 7'h00 : hex_glyph(w_cur_nib);
    w_seg_next  = SEG_OFF;
    w_dp_next   = DP_OFF;
    w_dig_next  = DIG_OFF;
    if (!w_guard) begin
      w_seg_next = SEG_ACTIVE_HIGH ? w_seg_logic  : ~w_seg_logic;
      w_dp_next  = SEG_ACTIVE_HIGH ? w_cur_dp     : ~w_cur_dp;
      w_dig_next = DIG_ACTIVE_HIGH ? w_dig_onehot : ~w_dig_onehot;
    end
  end

  logic [6:0]          r_seg;
  logic                r_dp;
  logic [N_DIGITS-1:0] r_dig;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
      r_dig <= DIG_OFF;
    end else begin
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
      r_dig <= w_dig_next;
    end
  end

  assign o_seg     = r_seg;
  assign o_dp      = r_dp;
  assign o_dig     = r_dig;
  assign o_pending = r_pending;

endmodule

// File: tb/tb_hex_7seg_mux_driver.sv
// ---------------------------------------------------------------------------
// tb_hex_7seg_mux_driver
//
// Bench for hex_7seg_mux_driver with 4 digits, 8-cycle slots, a 2-cycle
// guard and active-low polarity. The reference model tracks the elapsed
// cycle count since reset. It derives the slot position and the digit
// arithmetically from that count, and it keeps the shadow/display values as
// plain variables. The DUT outputs are compared with the model after every
// clock edge. Directed scenarios add literal expectations at chosen points.
// ---------------------------------------------------------------------------
module tb_hex_7seg_mux_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int G  = 2;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] val;
  logic [3:0]  dpi;
  logic        lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig;
  logic        pend;

  hex_7seg_mux_driver #(
    .N_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYCLES(G),
    .SEG_ACTIVE_HIGH(1'b0), .DIG_ACTIVE_HIGH(1'b0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_load(load), .i_value(val), .i_dp(dpi),
    .i_lz_en(lz), .o_seg(seg), .o_dp(dp), .o_dig(dig), .o_pending(pend)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          t;           // cycles since reset release
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_ddp, m_sdp;
  logic        m_pend;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_dig;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (time %0t, t=%0d)", name, act, exp, $time, t);
    end
  endtask

  // One clock cycle: predict the outputs from the pre-edge state and inputs,
  // advance the model across the edge, then compare on the falling edge.
  task automatic step();
    int p, k;
    logic [3:0] nib;
    logic blank;
    if (rst) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF;
    end else begin
      p = t % RD;
      k = (t / RD) % N;
      if (p < G) begin
        e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF;
      end else begin
        nib   = 4'(m_disp >> (4 * k));
        blank = lz && (k != 0) && ((m_disp >> (4 * k)) == 16'h0);
        e_seg = blank ? 7'h7F : ~glyph[nib];
        e_dp  = ~m_ddp[k];
        e_dig = ~(4'b0001 << k);
      end
    end
    @(posedge clk);
    if (rst) begin
      t = 0; m_disp = '0; m_shadow = '0; m_ddp = '0; m_sdp = '0; m_pend = 1'b0;
    end else begin
      if (load) begin
        m_shadow = val; m_sdp = dpi;
      end
      if ((t % FRAME) == FRAME - 1) begin
        m_disp = m_shadow; m_ddp = m_sdp; m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      t++;
    end
    @(negedge clk);
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("dig", 32'(dig), 32'(e_dig));
    chk("pending", 32'(pend), 32'(m_pend));
  endtask

  // Step until the next edge will sample frame position m.
  task automatic step_to(input int m);
    for (int i = 0; i < 2 * FRAME && (t % FRAME) != m; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    $display("load value=%04h dp=%b at frame pos %0d", v, d, t % FRAME);
    load = 1'b1; val = v; dpi = d;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; val = '0; dpi = '0; lz = 1'b0; t = 0;
    m_disp = '0; m_shadow = '0; m_ddp = '0; m_sdp = '0; m_pend = 1'b0;

    // 1: reset state, first digit enable 3 cycles after release
    repeat (3) step();
    chk("rst_dig", 32'(dig), 32'h0F);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_pend", 32'(pend), 32'h0);
    rst = 1'b0;
    step(); step();
    chk("guard_dig", 32'(dig), 32'hF);
    step();
    chk("first_dig", 32'(dig), 32'hE);

    // 2: load mid-frame, pending until commit, new value next frame
    step_to(12);
    do_load(16'h1234, 4'h0);
    chk("pend_set", 32'(pend), 32'h1);
    step_to(FRAME - 1);
    chk("pend_hold", 32'(pend), 32'h1);
    step();
    chk("pend_clr", 32'(pend), 32'h0);
    step_to(2); step();
    chk("d0_4", 32'(seg), 32'h4C);
    chk("d0_en", 32'(dig), 32'hE);
    step_to(RD + 2); step();
    chk("d1_3", 32'(seg), 32'h06);

    // 3: leading-zero suppression
    lz = 1'b1;
    do_load(16'h0050, 4'h0);
    step_to(FRAME - 1); step();
    step_to(2); step();
    chk("lz_d0", 32'(seg), 32'h01);
    step_to(RD + 2); step();
    chk("lz_d1", 32'(seg), 32'h24);
    step_to(2 * RD + 2); step();
    chk("lz_d2", 32'(seg), 32'h7F);
    chk("lz_d2_en", 32'(dig), 32'hB);
    step_to(3 * RD + 4); step();
    chk("lz_d3", 32'(seg), 32'h7F);
    do_load(16'h0000, 4'h0);
    step_to(FRAME - 1); step();
    step_to(RD + 3); step();
    chk("zero_d1", 32'(seg), 32'h7F);
    step_to(2); step();
    chk("zero_d0", 32'(seg), 32'h01);

    // 4: last write wins while pending
    step_to(5);  do_load(16'h1111, 4'h0);
    step_to(9);  do_load(16'h2222, 4'h0);
    step_to(FRAME - 1);
    chk("lww_pend", 32'(pend), 32'h1);
    step();
    chk("lww_clr", 32'(pend), 32'h0);
    step_to(2); step();
    chk("lww_d0", 32'(seg), 32'h12);

    // 5: load on the commit cycle goes straight to the display
    step_to(FRAME - 1);
    do_load(16'hABCD, 4'h0);
    chk("bypass_pend", 32'(pend), 32'h0);
    step_to(2); step();
    chk("bypass_d0", 32'(seg), 32'h42);

    // 6: dp shown on a blanked digit
    step_to(4);
    do_load(16'h0000, 4'b0100);
    step_to(FRAME - 1); step();
    step_to(2 * RD + 2); step();
    chk("dp_dig", 32'(dig), 32'hB);
    chk("dp_seg", 32'(seg), 32'h7F);
    chk("dp_dp", 32'(dp), 32'h0);

    // Randomized traffic including mid-slot resets and lz toggling
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) lz = ~lz;
      val = 16'($urandom);
      dpi = 4'($urandom);
      load = ($urandom_range(0, 5) == 0);
      if (load)
        $display("load value=%04h dp=%b rst=%0d at frame pos %0d", val, dpi, rst, t % FRAME);
      step();
    end
    load = 1'b0; rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
